// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC redirect logic: source ordering,
// default sizes and the next-PC selection encoding.
package pc_pkg;

    // Redirect source indices; lower index = older stage = higher priority
    localparam int SRC_MEM_LOAD = 0;
    localparam int SRC_LHI      = 1;
    localparam int SRC_ALU      = 2;
    localparam int SRC_BEQ      = 3;
    localparam int SRC_JLR      = 4;
    localparam int SRC_JAL      = 5;
    localparam int SRC_SPARE    = 6;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_NUM_SRC = 7;
    localparam int DEFAULT_CNT_W   = 16;

    // Where the next PC comes from on a writable cycle
    typedef enum logic [1:0] {
        NPC_SEQ     = 2'd0,
        NPC_LIVE    = 2'd1,
        NPC_PENDING = 2'd2
    } npc_sel_e;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Bus between the pipeline (redirect sources, stall control) and the PC unit.
interface pc_redirect_unit_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 7,
    parameter int CNT_W   = 16,
    parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic                     pc_write;
    logic [NUM_SRC-1:0]       redir_valid;
    logic [NUM_SRC*WIDTH-1:0] redir_target;
    logic [WIDTH-1:0]         pc_out;
    logic [WIDTH-1:0]         inc_pc_out;
    logic                     redir_taken;
    logic [SRC_W-1:0]         redir_src;
    logic [NUM_SRC-1:0]       flush_mask;
    logic                     pending;
    logic [CNT_W-1:0]         redir_count;

    // Pipeline side: drives requests and stall, observes the PC state
    modport master (
        output pc_write, redir_valid, redir_target,
        input  pc_out, inc_pc_out, redir_taken, redir_src, flush_mask, pending, redir_count
    );

    // PC unit side
    modport slave (
        input  pc_write, redir_valid, redir_target,
        output pc_out, inc_pc_out, redir_taken, redir_src, flush_mask, pending, redir_count
    );
endinterface

// File: rtl/pc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request bit and whether any is set.
module pc_prio_enc #(
    parameter int NUM_SRC = 7,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with prioritised redirects, a one-entry buffer for
// redirects arriving during a stall, and taken-redirect reporting.
module pc_redirect_unit
    import pc_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NUM_SRC  = DEFAULT_NUM_SRC,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    pc_redirect_unit_if.slave   bus
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [WIDTH-1:0]   pc_q;
    logic               pend_valid_q;
    logic [WIDTH-1:0]   pend_tgt_q;
    logic [SRC_W-1:0]   pend_src_q;
    logic               taken_q;
    logic [SRC_W-1:0]   src_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [CNT_W-1:0]   count_q;

    logic               win_found;
    logic [SRC_W-1:0]   win_idx;
    logic [WIDTH-1:0]   win_target;

    npc_sel_e           npc_sel;
    logic [WIDTH-1:0]   npc;
    logic [SRC_W-1:0]   take_src;
    logic               take;
    logic               latch_pend;
    logic [NUM_SRC-1:0] take_mask;

    pc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (SRC_W)
    ) u_winner (
        .req   (bus.redir_valid),
        .found (win_found),
        .index (win_idx)
    );

    assign win_target = bus.redir_target[int'(win_idx)*WIDTH +: WIDTH];

    // Decide the next-PC source; live requests beat the buffered one because they are newer
    always_comb begin
        npc_sel    = NPC_SEQ;
        latch_pend = 1'b0;
        if (bus.pc_write) begin
            if (win_found) begin
                npc_sel = NPC_LIVE;
            end else if (pend_valid_q) begin
                npc_sel = NPC_PENDING;
            end
        end else begin
            latch_pend = win_found && (!pend_valid_q || (win_idx < pend_src_q));
        end
    end

    // Next-PC mux plus the flush mask for whichever source is being taken
    always_comb begin
        npc      = pc_q + WIDTH'(1);
        take_src = src_q;
        take     = 1'b0;
        case (npc_sel)
            NPC_LIVE: begin
                npc      = win_target;
                take_src = win_idx;
                take     = 1'b1;
            end
            NPC_PENDING: begin
                npc      = pend_tgt_q;
                take_src = pend_src_q;
                take     = 1'b1;
            end
            default: ;
        endcase
        for (int j = 0; j < NUM_SRC; j++) begin
            take_mask[j] = (j > int'(take_src));
        end
    end

    // PC, pending buffer and redirect reporting registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= WIDTH'(RESET_PC);
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
            pend_src_q   <= '0;
            taken_q      <= 1'b0;
            src_q        <= '0;
            mask_q       <= '0;
            count_q      <= '0;
        end else begin
            if (bus.pc_write) begin
                pc_q         <= npc;
                pend_valid_q <= 1'b0;
            end else if (latch_pend) begin
                pend_valid_q <= 1'b1;
                pend_tgt_q   <= win_target;
                pend_src_q   <= win_idx;
            end
            taken_q <= take;
            if (take) begin
                src_q  <= take_src;
                mask_q <= take_mask;
                if (count_q != {CNT_W{1'b1}}) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else begin
                mask_q <= '0;
            end
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.inc_pc_out  = pc_q + WIDTH'(1);
    assign bus.redir_taken = taken_q;
    assign bus.redir_src   = src_q;
    assign bus.flush_mask  = mask_q;
    assign bus.pending     = pend_valid_q;
    assign bus.redir_count = count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the PC unit.
module tb_pc_redirect_unit;

    localparam int W  = 16;
    localparam int NS = 7;

    logic clk;
    logic reset;

    pc_redirect_unit_if #(.WIDTH(W), .NUM_SRC(NS), .CNT_W(16)) bus ();

    pc_redirect_unit #(
        .WIDTH    (W),
        .NUM_SRC  (NS),
        .RESET_PC (0),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state, kept as plain integers
    int m_pc;
    int m_pend;
    int m_pend_tgt;
    int m_pend_src;
    int m_taken;
    int m_src;
    int m_mask;
    int m_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check_output("pc_out",      32'(bus.pc_out),      32'(m_pc));
        check_output("inc_pc_out",  32'(bus.inc_pc_out),  32'((m_pc + 1) % 65536));
        check_output("redir_taken", 32'(bus.redir_taken), 32'(m_taken));
        check_output("redir_src",   32'(bus.redir_src),   32'(m_src));
        check_output("flush_mask",  32'(bus.flush_mask),  32'(m_mask));
        check_output("pending",     32'(bus.pending),     32'(m_pend));
        check_output("redir_count", 32'(bus.redir_count), 32'(m_count));
    endtask

    function automatic int find_winner(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pend = 0; m_pend_tgt = 0; m_pend_src = 0;
        m_taken = 0; m_src = 0; m_mask = 0; m_count = 0;
    endtask

    // One clock edge of the model, straight from the redirect rules
    task automatic model_edge(input logic pw, input logic [NS-1:0] v, input logic [NS*W-1:0] tg);
        int w;
        int took;
        int src;
        w    = find_winner(v);
        took = 0;
        src  = 0;
        if (pw) begin
            if (w >= 0) begin
                m_pc = int'(tg[w*W +: W]); took = 1; src = w;
            end else if (m_pend != 0) begin
                m_pc = m_pend_tgt; took = 1; src = m_pend_src;
            end else begin
                m_pc = (m_pc + 1) % 65536;
            end
            m_pend = 0;
        end else if (w >= 0) begin
            if (m_pend == 0 || w < m_pend_src) begin
                m_pend = 1; m_pend_tgt = int'(tg[w*W +: W]); m_pend_src = w;
            end
        end
        m_taken = took;
        if (took != 0) begin
            m_src   = src;
            m_mask  = ((1 << NS) - 1) & ~((1 << (src + 1)) - 1);
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
        end else begin
            m_mask = 0;
        end
    endtask

    task automatic apply_stimulus(input logic pw, input logic [NS-1:0] v, input logic [NS*W-1:0] tg);
        bus.pc_write     = pw;
        bus.redir_valid  = v;
        bus.redir_target = tg;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(pw, v, tg);
        #1;
        compare_all();
    endtask

    task automatic apply_reset(input int cycles, input logic pw);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            apply_stimulus(pw, '0, '0);
        end
        reset = 1'b0;
    endtask

    function automatic logic [NS*W-1:0] one_target(input int idx, input logic [W-1:0] t);
        logic [NS*W-1:0] r;
        r = '0;
        r[idx*W +: W] = t;
        return r;
    endfunction

    initial begin
        logic [NS*W-1:0] tg;
        logic [NS-1:0]   v;
        logic            pw;

        reset = 1'b1;
        bus.pc_write = 1'b0;
        bus.redir_valid = '0;
        bus.redir_target = '0;
        model_reset();

        // Reset state
        apply_reset(2, 1'b1);
        check_output("reset_pc", 32'(bus.pc_out), 32'h0);
        check_output("reset_inc", 32'(bus.inc_pc_out), 32'h1);

        // Sequential fetch
        for (int k = 0; k < 4; k++) apply_stimulus(1'b1, '0, '0);
        check_output("seq_pc4", 32'(bus.pc_out), 32'h4);
        apply_stimulus(1'b1, '0, '0);

        // Two live requests, source 3 wins
        tg = one_target(3, 16'h0040) | one_target(5, 16'h0090);
        apply_stimulus(1'b1, 7'b0101000, tg);
        check_output("win_pc", 32'(bus.pc_out), 32'h0040);
        check_output("win_mask", 32'(bus.flush_mask), 32'h70);
        check_output("win_count", 32'(bus.redir_count), 32'h1);

        // Stall: source 5 then higher-priority source 2 overwrites
        apply_stimulus(1'b0, 7'b0100000, one_target(5, 16'h0200));
        apply_stimulus(1'b0, 7'b0000100, one_target(2, 16'h0100));
        check_output("stall_pend", 32'(bus.pending), 32'h1);
        apply_stimulus(1'b1, '0, '0);
        check_output("stall_pc", 32'(bus.pc_out), 32'h0100);
        check_output("stall_src", 32'(bus.redir_src), 32'h2);

        // Stall: lower-priority source 6 is dropped
        apply_stimulus(1'b0, 7'b0100000, one_target(5, 16'h0200));
        apply_stimulus(1'b0, 7'b1000000, one_target(6, 16'h0777));
        apply_stimulus(1'b1, '0, '0);
        check_output("drop_pc", 32'(bus.pc_out), 32'h0200);

        // Pending full, live request at release wins
        apply_stimulus(1'b0, 7'b0100000, one_target(5, 16'h0200));
        apply_stimulus(1'b1, 7'b0010000, one_target(4, 16'h0333));
        check_output("live_pc", 32'(bus.pc_out), 32'h0333);
        check_output("live_pend", 32'(bus.pending), 32'h0);

        // Redirect to the current PC is still taken
        apply_stimulus(1'b1, 7'b0000001, one_target(0, 16'h0333));
        check_output("same_taken", 32'(bus.redir_taken), 32'h1);

        // Wrap-around
        apply_stimulus(1'b1, 7'b0000001, one_target(0, 16'hFFFF));
        apply_stimulus(1'b1, '0, '0);
        check_output("wrap_pc", 32'(bus.pc_out), 32'h0000);

        // Reset during a stall discards the pending redirect
        apply_stimulus(1'b0, 7'b0000010, one_target(1, 16'h1234));
        apply_reset(1, 1'b0);
        check_output("rst_pend", 32'(bus.pending), 32'h0);
        apply_stimulus(1'b1, '0, '0);
        check_output("rst_pc", 32'(bus.pc_out), 32'h1);
        check_output("rst_taken", 32'(bus.redir_taken), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                apply_reset(1, 1'($urandom_range(0, 1)));
            end else begin
                pw = ($urandom_range(0, 3) != 0);
                v  = '0;
                for (int i = 0; i < NS; i++) v[i] = ($urandom_range(0, 5) == 0);
                for (int i = 0; i < NS; i++) begin
                    tg[i*W +: W] = ($urandom_range(0, 7) == 0) ? bus.pc_out : W'($urandom);
                end
                apply_stimulus(pw, v, tg);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Parametrised program-counter unit for the fetch stage. It owns the PC register and resolves any number of prioritised redirect requests from later pipeline stages. It holds a redirect that arrives during a fetch stall until the PC can be written, and reports each taken redirect with the stages to squash and a running count. It replaces the fixed 8-way PC mux and negedge select logic; the PC and all selection are now synchronous to one posedge clock.

## Interface
Parameters:
- WIDTH, 16, PC/target width in bits
- NUM_SRC, 7, number of redirect sources; index 0 = highest priority (oldest stage)
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of redirect counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_write  in  1  1 = PC may update this cycle; 0 = fetch stall, PC holds
- redir_valid  in  NUM_SRC  per-source redirect request, level, sampled each edge
- redir_target  in  NUM_SRC*WIDTH  source i target at bits [i*WIDTH +: WIDTH]
- pc_out  out  WIDTH  current PC (registered)
- inc_pc_out  out  WIDTH  pc_out + 1, combinational, wraps modulo 2^WIDTH
- redir_taken  out  1  registered pulse: PC was loaded from a redirect at the last edge
- redir_src  out  $clog2(NUM_SRC) (min 1)  index of the source that produced the last taken redirect
- flush_mask  out  NUM_SRC  registered; bit j set for every j > redir_src while redir_taken=1, else all 0
- pending  out  1  a redirect is buffered awaiting pc_write
- redir_count  out  CNT_W  number of taken redirects since reset, saturating

## Operation
- Winner: lowest index i with redir_valid[i]=1. No valid bit means no winner.
- Pending buffer holds a target, a source index and a valid flag.
- Next-PC priority when pc_write=1:
  - winner present: PC <= winner target
  - else pending valid: PC <= pending target
  - else: PC <= PC+1
  - pending clears in all three cases.
- When pc_write=0: PC holds.
  - If a winner is present and pending is empty, the winner is latched.
  - If pending is full, a winner with a strictly lower index than the pending source overwrites it. An equal or higher index is dropped.
- Winner and pending both present with pc_write=1: the winner is used, because live inputs are newer than the buffered request. The pending request is discarded.
- A redirect counts as taken only when it loads the PC. On that edge:
  - redir_taken <= 1
  - redir_src <= source index
  - flush_mask <= mask of indices above it
  - redir_count <= redir_count+1, holding at all-ones
- Otherwise redir_taken <= 0 and flush_mask <= 0. redir_src holds its last value.
- The target value is not compared against the current PC. A redirect to the current PC is still taken and counted.

## Timing
- Reset values: pc_out=RESET_PC, pending=0, redir_taken=0, redir_src=0, flush_mask=0, redir_count=0. inc_pc_out=RESET_PC+1.
- Reset has priority over pc_write and redir_valid. Asserting reset mid-stall discards the pending redirect.
- Latency: redirect valid in cycle N with pc_write=1 gives pc_out=target in cycle N+1. redir_taken, redir_src and flush_mask are valid in N+1, coincident with the new PC.
- Redirect during a stall (cycles N..M with pc_write=0, pc_write=1 at M+1, no new request) gives pc_out=target in M+2.
- Wrap-around: PC=2^WIDTH-1 with no redirect gives PC=0.
- redir_valid and pc_write are consumed at the same edge; there is no handshake back to sources. A source must hold its request if it needs a retry, and must not depend on being acknowledged.

## Structure
- Shared package pc_pkg holds:
  - source index constants, matching the old mux ordering: SRC_MEM_LOAD=0, SRC_LHI=1, SRC_ALU=2, SRC_BEQ=3, SRC_JLR=4, SRC_JAL=5, SRC_SPARE=6
  - the default WIDTH and NUM_SRC values
- Sub-module pc_prio_enc, parametrised on NUM_SRC. Outputs are found and index: lowest set bit and a found flag, purely combinational. Instantiated once for the winner.
- Expected size: roughly 150–250 lines.

## Test plan
Default parameters.
- Reset with reset=1 for 2 cycles, then 5 cycles with pc_write=1 and no requests -> pc_out 0,1,2,3,4; redir_count=0.
- redir_valid=7'b0101000, targets[3]=16'h0040 and [5]=16'h0090, pc_write=1 -> next pc_out=16'h0040, redir_taken=1, redir_src=3, flush_mask=7'b1110000, redir_count=1.
- Stall:
  - pc_write=0; source 5 requests 16'h0200, then next cycle source 2 requests 16'h0100 -> pending=1, PC unchanged.
  - Release pc_write with no requests -> pc_out=16'h0100, redir_src=2.
  - Variant where the second request comes from source 6 -> pc_out=16'h0200.
- Pending full and live source 4 request 16'h0333 at release -> pc_out=16'h0333, pending=0.
- PC loaded to 16'hFFFF via redirect, one free cycle -> pc_out=16'h0000.
- Assert reset during a stall with pending=1 -> pc_out=0, pending=0. Release pc_write -> pc_out=1, with no redirect taken.
